multi_digit_compare: RTL and testbench
======================================

MULTI_DIGIT_COMPARE -- requirements
Module: multi_digit_compare

Interface
REQ-001 Parameter W, default 8: operand width in bits; SHALL be even and >= 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a compare; sampled only when busy=0.
REQ-005 a  input  W  operand A; captured on an accepted start.
REQ-006 b  input  W  operand B; captured on an accepted start.
REQ-007 busy  output  1  high while a compare is in progress (state RUN).
REQ-008 done  output  1  one-cycle pulse when the result becomes valid.
REQ-009 agtb  output  1  result: A > B (unsigned).
REQ-010 aeqb  output  1  result: A == B.
REQ-011 altb  output  1  result: A < B (unsigned).

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE; there SHALL be no other reachable state.
REQ-013 Accepted start (start=1 in IDLE or DONE): latch a/b into shift registers, set digit index to W/2-1, clear agtb/aeqb/altb to 0, enter RUN next cycle.
REQ-014 start while busy=1 SHALL be ignored; latched operands and progress are unaffected.
REQ-015 In RUN, each cycle compares one 2-bit digit, MSB-first, from the latched operands (a[W-1:W-2] vs b[W-1:W-2] first).
REQ-016 The first unequal digit SHALL decide the result; later digits SHALL NOT change it.
REQ-017 RUN -> DONE after the last digit (index 0) is compared, or earlier as given in REQ-025.
REQ-018 In DONE for exactly one cycle: done=1, exactly one of agtb/aeqb/altb = 1; the state then returns to IDLE unless start=1 (REQ-013).
REQ-019 The result outputs SHALL hold their value after DONE until the next accepted start or reset.
REQ-020 Without early exit, latency SHALL be: start accepted at edge k -> done=1 during cycle k+W/2+1.
REQ-021 The results SHALL be unsigned magnitude; A == B only when all W/2 digits are equal.

Reset
REQ-022 reset=1 at a clock edge SHALL force state IDLE with busy=0, done=0, agtb=0, aeqb=0, altb=0, digit index 0, and cleared operand registers.
REQ-023 reset SHALL take priority over start and SHALL abort a compare in progress; no done pulse is issued for the aborted operation.

Configuration
REQ-024 Macro MULTI_DIGIT_COMPARE_EARLY_EXIT_EN selects the early-exit behaviour.
REQ-025 Defined: RUN -> DONE on the cycle after the first unequal digit, so latency = (number of leading equal digits + 1) + 1 cycles.
REQ-026 Undefined: RUN always lasts W/2 cycles, regardless of the data; latency is fixed per REQ-020.

Structure
REQ-027 A shared package multi_digit_compare_pkg SHALL hold the state enum type (IDLE/RUN/DONE) and a 2-bit digit typedef.
REQ-028 One sub-module, digit2_compare, SHALL be instantiated: a combinational 2-bit digit comparator with outputs gt, eq, lt; all sequencing stays in the top module.

Verification
REQ-029 The bench SHALL check, with W=8 and no macro: a=0xA5, b=0xA5, start pulse -> busy for 4 cycles, done at k+5, aeqb=1 and the other two results 0.
REQ-030 The bench SHALL check, with W=8: a=0x80, b=0x7F -> agtb=1; with the macro, done at k+2; without it, done at k+5.
REQ-031 The bench SHALL check, with W=8: a=0x12, b=0x13 (differs only in the last digit) -> altb=1, done at k+5 in both builds.
REQ-032 The bench SHALL check: a second start while busy, with different operands -> ignored; the result matches the first operands only.
REQ-033 The bench SHALL check: reset asserted mid-RUN -> the next cycle shows IDLE and all outputs 0, with no done pulse; a new start then completes correctly.
REQ-034 The bench SHALL check: start=1 during the DONE cycle -> the new compare is accepted back-to-back with no idle gap, and the previous result is cleared the next cycle.

Source files
------------

// File: rtl/multi_digit_compare_pkg.sv
// Shared types for the multi-digit comparator: FSM state encoding and 2-bit digit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multi_digit_compare_pkg;

    // Three-state sequencer; the 2-bit encoding leaves 2'd3 unused and unreachable
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One radix-4 digit of an operand
    typedef logic [1:0] digit_t;

    localparam int DIGIT_W = 2;

endpackage

// File: rtl/multi_digit_compare_digit2_compare.sv
// Combinational magnitude compare of one 2-bit digit; exactly one of gt/eq/lt is high.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the outputs follow the inputs.
module digit2_compare
    import multi_digit_compare_pkg::*;
(
    input  digit_t a,
    input  digit_t b,
    output logic   gt,
    output logic   eq,
    output logic   lt
);

    // Unsigned compare of a single digit
    always_comb begin
        gt = (a > b);
        eq = (a == b);
        lt = (a < b);
    end

endmodule

// File: rtl/multi_digit_compare.sv
// Sequential unsigned compare of two W-bit operands, one 2-bit digit per cycle, MSB digit first.
// Latency: start accepted at edge k -> done during cycle k+W/2+1; with MULTI_DIGIT_COMPARE_EARLY_EXIT_EN, (leading equal digits + 1) + 1.
// Backpressure: start is ignored while busy; a start in the DONE cycle is accepted back-to-back.
module multi_digit_compare
    import multi_digit_compare_pkg::*;
#(
    parameter int W = 8    // operand width; must be even and >= 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         agtb,
    output logic         aeqb,
    output logic         altb
);

    localparam int ND = W / DIGIT_W;
    localparam int IW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [IW-1:0] IDX_FIRST = IW'(ND - 1);

    state_t         state_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [IW-1:0]  idx_q;
    logic           gt_q;       // an earlier digit already decided A > B
    logic           lt_q;       // an earlier digit already decided A < B
    logic           eq_q;       // every digit so far was equal
    logic           busy_q;
    logic           done_q;
    logic           agtb_q;
    logic           aeqb_q;
    logic           altb_q;

    digit_t         dig_a;
    digit_t         dig_b;
    logic           dig_gt;
    logic           dig_eq;
    logic           dig_lt;

    logic           gt_d;
    logic           lt_d;
    logic           eq_d;
    logic           exit_d;

    // The operand registers shift left, so the digit under test is always the top pair
    assign dig_a = a_q[W-1 -: DIGIT_W];
    assign dig_b = b_q[W-1 -: DIGIT_W];

    digit2_compare u_digit (
        .a  (dig_a),
        .b  (dig_b),
        .gt (dig_gt),
        .eq (dig_eq),
        .lt (dig_lt)
    );

    // Fold the current digit into the running verdict; the first unequal digit wins
    always_comb begin
        gt_d   = gt_q | (eq_q & dig_gt);
        lt_d   = lt_q | (eq_q & dig_lt);
        eq_d   = eq_q & dig_eq;
`ifdef MULTI_DIGIT_COMPARE_EARLY_EXIT_EN
        exit_d = (idx_q == '0) | (eq_q & ~dig_eq);
`else
        exit_d = (idx_q == '0);
`endif
    end

    // Sequencer: accept, step through digits, publish a one-cycle done with held results
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            agtb_q  <= 1'b0;
            aeqb_q  <= 1'b0;
            altb_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    a_q  <= a_q << DIGIT_W;
                    b_q  <= b_q << DIGIT_W;
                    gt_q <= gt_d;
                    lt_q <= lt_d;
                    eq_q <= eq_d;
                    if (exit_d) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        agtb_q  <= gt_d;
                        aeqb_q  <= eq_d;
                        altb_q  <= lt_d;
                    end else begin
                        idx_q <= idx_q - IW'(1);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; results hold otherwise
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        a_q     <= a;
                        b_q     <= b;
                        idx_q   <= IDX_FIRST;
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        eq_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        agtb_q  <= 1'b0;
                        aeqb_q  <= 1'b0;
                        altb_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign agtb = agtb_q;
    assign aeqb = aeqb_q;
    assign altb = altb_q;

endmodule

// File: tb/tb_multi_digit_compare.sv
// Directed bench for multi_digit_compare with W=8, in default or early-exit build.
// Cycle j is the clock period ending at edge j; outputs are sampled on the falling edge.
// An accepted start at edge k is first observed in cycle k+1.
module tb_multi_digit_compare;

    localparam int W = 8;
`ifdef MULTI_DIGIT_COMPARE_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    // 0x80 vs 0x7F: first digit 10 vs 01 differs
    localparam int LAT_80_7F = EE ? 2 : 5;
    // 0x30 vs 0x20: digits 00 11.. vs 00 10.., second digit differs
    localparam int LAT_30_20 = EE ? 3 : 5;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         agtb;
    logic         aeqb;
    logic         altb;

    int checks = 0;
    int errors = 0;

    multi_digit_compare #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .agtb  (agtb),
        .aeqb  (aeqb),
        .altb  (altb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present a start for one edge; returns at the falling edge of cycle k+1
    task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done starting in cycle k+cyc0, then check latency, busy length and results
    task automatic wait_done(input string tag, input int exp_lat,
                             input logic eg, input logic ee, input logic el,
                             input int cyc0, input int bcnt0, input bit tail);
        int cyc  = cyc0;
        int bcnt = bcnt0;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chkn({tag, " latency"}, cyc, exp_lat);
        chkn({tag, " busy_cycles"}, bcnt, exp_lat - 1);
        chk1({tag, " agtb"}, agtb, eg);
        chk1({tag, " aeqb"}, aeqb, ee);
        chk1({tag, " altb"}, altb, el);
        if (tail) begin
            @(negedge clk);
            chk1({tag, " done_pulse_ends"}, done, 1'b0);
            chk1({tag, " idle_after"}, busy, 1'b0);
            chk1({tag, " agtb_hold"}, agtb, eg);
            chk1({tag, " aeqb_hold"}, aeqb, ee);
            chk1({tag, " altb_hold"}, altb, el);
        end
    endtask

    initial begin
        bit seen;
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state, with start held high to show reset wins
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst busy", busy, 1'b0);
        chk1("rst done", done, 1'b0);
        chk1("rst agtb", agtb, 1'b0);
        chk1("rst aeqb", aeqb, 1'b0);
        chk1("rst altb", altb, 1'b0);
        start = 1'b0;
        reset = 1'b0;

        // Equal operands: all four digits compared, aeqb
        do_start(8'hA5, 8'hA5);
        chk1("eq busy_first", busy, 1'b1);
        wait_done("eq", 5, 1'b0, 1'b1, 1'b0, 1, 0, 1'b1);

        // MSB digit decides A > B
        do_start(8'h80, 8'h7F);
        wait_done("gt_msb", LAT_80_7F, 1'b1, 1'b0, 1'b0, 1, 0, 1'b1);

        // Only the last digit differs: A < B, full latency in both builds
        do_start(8'h12, 8'h13);
        wait_done("lt_lsb", 5, 1'b0, 1'b0, 1'b1, 1, 0, 1'b1);

        // Start while busy with different operands must be ignored
        do_start(8'h30, 8'h20);
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h20;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ign", LAT_30_20, 1'b1, 1'b0, 1'b0, 2, 1, 1'b1);

        // Reset in the middle of RUN aborts without a done pulse
        do_start(8'h12, 8'h13);
        @(negedge clk);
        chk1("abort busy_mid", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk1("abort busy", busy, 1'b0);
        chk1("abort done", done, 1'b0);
        chk1("abort agtb", agtb, 1'b0);
        chk1("abort aeqb", aeqb, 1'b0);
        chk1("abort altb", altb, 1'b0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk1("abort no_done", seen, 1'b0);
        do_start(8'h55, 8'h54);
        wait_done("post_abort", 5, 1'b1, 1'b0, 1'b0, 1, 0, 1'b1);

        // Start during DONE is taken immediately and clears the old result
        do_start(8'h01, 8'h02);
        wait_done("b2b_first", 5, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0);
        start = 1'b1;
        a     = 8'h40;
        b     = 8'h40;
        @(negedge clk);
        start = 1'b0;
        chk1("b2b busy", busy, 1'b1);
        chk1("b2b done", done, 1'b0);
        chk1("b2b altb_clr", altb, 1'b0);
        chk1("b2b aeqb_clr", aeqb, 1'b0);
        chk1("b2b agtb_clr", agtb, 1'b0);
        wait_done("b2b_second", 5, 1'b0, 1'b1, 1'b0, 1, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
